// File: rtl/axi_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_traffic_gen
// Description : AXI4 initiator that writes a sequence of INCR bursts with a
//               self-describing data pattern, reads each one back, and counts
//               any response or data mismatches. One burst is in flight at a
//               time: write, write response, read, then the next burst.
//               Optional latency statistics: AXI_TRAFFIC_GEN_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_traffic_gen #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TXN_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]              burst_len,
  input  logic [7:0]              num_bursts,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             err_cnt,
`ifdef AXI_TRAFFIC_GEN_PERF_EN
  output logic [15:0]             lat_max,
  output logic [31:0]             lat_sum,
`endif
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                  state;
  logic [7:0]              len_r;
  logic [7:0]              nb_r;
  logic [7:0]              burst_idx;
  logic [7:0]              wbeat;
  logic [7:0]              rbeat;
  logic [ADDR_WIDTH-1:0]   burst_base;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [ADDR_WIDTH-1:0]   raddr;
  logic [ADDR_WIDTH-1:0]   burst_stride;
  logic [DATA_WIDTH-1:0]   rdata_exp;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                    r_last_beat;
  logic [2:0]              err_inc;
  logic [16:0]             err_sum;
  logic [15:0]             err_next;

  // Data word for a beat: low 16 address bits, burst index, beat index.
  function automatic logic [DATA_WIDTH-1:0] beat_pattern(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [7:0]            kidx,
    input logic [7:0]            bidx
  );
    logic [31:0] addr32;
    logic [31:0] pat;
    addr32 = 32'(addr);
    pat    = {addr32[15:0], kidx, bidx};
    return DATA_WIDTH'(pat);
  endfunction

  // Channel payloads come straight from registers that only move on a
  // handshake, so they hold steady across any stall.
  assign m_axi_awid    = ID_WIDTH'(TXN_ID);
  assign m_axi_awaddr  = burst_base;
  assign m_axi_awlen   = len_r;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = beat_pattern(waddr, burst_idx, wbeat);
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (wbeat == len_r);
  assign m_axi_arid    = ID_WIDTH'(TXN_ID);
  assign m_axi_araddr  = burst_base;
  assign m_axi_arlen   = len_r;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;

  assign aw_hs        = m_axi_awvalid && m_axi_awready;
  assign w_hs         = m_axi_wvalid  && m_axi_wready;
  assign b_hs         = m_axi_bvalid  && m_axi_bready;
  assign ar_hs        = m_axi_arvalid && m_axi_arready;
  assign r_hs         = m_axi_rvalid  && m_axi_rready;
  assign r_last_beat  = (rbeat == len_r);
  assign rdata_exp    = beat_pattern(raddr, burst_idx, rbeat);
  assign burst_stride = ADDR_WIDTH'((32'(len_r) + 32'd1) * 32'(BYTES));

  // Number of independent faults seen on this cycle's B or R handshake.
  always_comb begin
    err_inc = 3'd0;
    if (b_hs) begin
      err_inc = 3'(m_axi_bid != ID_WIDTH'(TXN_ID)) + 3'(m_axi_bresp != 2'b00);
    end
    if (r_hs) begin
      err_inc = 3'(m_axi_rid != ID_WIDTH'(TXN_ID)) + 3'(m_axi_rresp != 2'b00)
              + 3'(m_axi_rdata != rdata_exp) + 3'(m_axi_rlast != r_last_beat);
    end
    err_sum  = {1'b0, err_cnt} + 17'(err_inc);
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // Sequencer: write burst, collect response, read back, repeat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      len_r         <= '0;
      nb_r          <= '0;
      burst_idx     <= '0;
      wbeat         <= '0;
      rbeat         <= '0;
      burst_base    <= '0;
      waddr         <= '0;
      raddr         <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
    end else begin
      done    <= 1'b0;
      err_cnt <= err_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            len_r      <= burst_len;
            nb_r       <= num_bursts;
            burst_idx  <= '0;
            burst_base <= base_addr;
            state      <= (num_bursts == 8'd0) ? S_DONE : S_AW;
          end
        end
        S_AW: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            wbeat         <= '0;
            waddr         <= burst_base;
            state         <= S_W;
          end else begin
            m_axi_awvalid <= 1'b1;
          end
        end
        S_W: begin
          if (w_hs) begin
            if (wbeat == len_r) begin
              m_axi_wvalid <= 1'b0;
              m_axi_bready <= 1'b1;
              state        <= S_B;
            end else begin
              wbeat <= wbeat + 8'd1;
              waddr <= waddr + ADDR_WIDTH'(BYTES);
            end
          end
        end
        S_B: begin
          if (b_hs) begin
            m_axi_bready <= 1'b0;
            state        <= S_AR;
          end
        end
        S_AR: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            rbeat         <= '0;
            raddr         <= burst_base;
            state         <= S_R;
          end else begin
            m_axi_arvalid <= 1'b1;
          end
        end
        S_R: begin
          if (r_hs) begin
            // Leave after burst_len+1 beats even if RLAST never came.
            if (r_last_beat) begin
              m_axi_rready <= 1'b0;
              if (burst_idx + 8'd1 == nb_r) begin
                state <= S_DONE;
              end else begin
                burst_idx  <= burst_idx + 8'd1;
                burst_base <= burst_base + burst_stride;
                state      <= S_AW;
              end
            end else begin
              rbeat <= rbeat + 8'd1;
              raddr <= raddr + ADDR_WIDTH'(BYTES);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXI_TRAFFIC_GEN_PERF_EN
  logic [15:0] lat_cur;
  logic [15:0] lat_burst;
  logic [32:0] lat_sum_ext;
  logic        lat_count;

  // Cycles are counted from the VALID rise through the closing handshake.
  assign lat_count = (state == S_AW && m_axi_awvalid) || (state == S_W) || (state == S_B) ||
                     (state == S_AR && m_axi_arvalid) || (state == S_R);
  assign lat_burst   = (lat_cur == 16'hFFFF) ? 16'hFFFF : lat_cur + 16'd1;
  assign lat_sum_ext = {1'b0, lat_sum} + 33'(lat_burst);

  // Per-burst latency accumulation with saturating max and sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cur <= '0;
      lat_max <= '0;
      lat_sum <= '0;
    end else if (state == S_IDLE && start) begin
      lat_cur <= '0;
      lat_max <= '0;
      lat_sum <= '0;
    end else if (state == S_R && r_hs && r_last_beat) begin
      lat_cur <= '0;
      if (lat_burst > lat_max) begin
        lat_max <= lat_burst;
      end
      lat_sum <= lat_sum_ext[32] ? 32'hFFFF_FFFF : lat_sum_ext[31:0];
    end else if (lat_count && lat_cur != 16'hFFFF) begin
      lat_cur <= lat_cur + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
